// File: rtl/imm_enc_pkg.sv
// Shared constants and types for the RV32 immediate encoder.
// Format codes, fixed opcodes and the signed 12-bit immediate range.
package imm_enc_pkg;

  typedef enum logic [1:0] {
    FMT_I  = 2'd0,
    FMT_S  = 2'd1,
    FMT_B  = 2'd2,
    FMT_LI = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FIRST = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI   = 3'b000;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;

  function automatic logic fits_imm12(input logic [31:0] value);
    return ($signed(value) >= IMM12_MIN) && ($signed(value) <= IMM12_MAX);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer for one I/S/B-type word from fields and a 12-bit immediate.
// FMT_LI is packed as I-type; the top routes the LI pseudo-op through here as ADDI.
module imm_pack
  import imm_enc_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm12,
  output logic [31:0] word
);

  // B immediates are halfword offsets, so imm12[11:0] maps straight onto offset bits 12:1.
  always_comb begin
    word = '0;
    case (fmt)
      FMT_S:   word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode};
      FMT_B:   word = {imm12[11], imm12[9:4], rs2, rs1, funct3,
                       imm12[3:0], imm12[10], opcode};
      default: word = {imm12, rs1, funct3, rd, opcode};
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Valid/ready instruction encoder: packs I/S/B words and expands LI into LUI+ADDI.
// Output is fully registered; a pending ADDI waits in a side register behind its LUI.
module imm_encoder
  import imm_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] pend_q, pend_d;

  logic        is_li;
  logic        in_range;
  logic        li_two;
  logic        accept;
  logic [1:0]  prim_fmt;
  logic [6:0]  prim_opcode;
  logic [2:0]  prim_funct3;
  logic [4:0]  prim_rs1;
  logic [31:0] prim_word;
  logic [31:0] addi_word;
  logic [19:0] lui_hi;
  logic [31:0] lui_word;
  logic [31:0] load_inst;
  logic        load_last;
  logic        load_err;

  assign is_li    = (in_fmt == FMT_LI);
  assign in_range = fits_imm12(in_imm);
  assign li_two   = is_li && !in_range;

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending its low 12 bits.
  assign lui_hi   = in_imm[31:12] + {19'd0, in_imm[11]};
  assign lui_word = {lui_hi, in_rd, OPC_LUI};

  assign prim_fmt    = is_li ? FMT_I     : in_fmt;
  assign prim_opcode = is_li ? OPC_OPIMM : in_opcode;
  assign prim_funct3 = is_li ? F3_ADDI   : in_funct3;
  assign prim_rs1    = is_li ? 5'd0      : in_rs1;

  imm_pack u_prim (
    .fmt    (prim_fmt),
    .opcode (prim_opcode),
    .funct3 (prim_funct3),
    .rd     (in_rd),
    .rs1    (prim_rs1),
    .rs2    (in_rs2),
    .imm12  (in_imm[11:0]),
    .word   (prim_word)
  );

  imm_pack u_second (
    .fmt    (FMT_I),
    .opcode (OPC_OPIMM),
    .funct3 (F3_ADDI),
    .rd     (in_rd),
    .rs1    (in_rd),
    .rs2    (5'd0),
    .imm12  (in_imm[11:0]),
    .word   (addi_word)
  );

  assign load_inst = li_two ? lui_word : prim_word;
  assign load_last = !li_two;
  assign load_err  = !is_li && !in_range;

  assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_inst  = inst_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    last_d  = last_q;
    err_d   = err_q;
    pend_d  = pend_q;
    case (state_q)
      ST_EMPTY, ST_ONE: begin
        if (accept) begin
          inst_d  = load_inst;
          last_d  = load_last;
          err_d   = load_err;
          pend_d  = addi_word;
          state_d = li_two ? ST_FIRST : ST_ONE;
        end else if ((state_q == ST_ONE) && out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FIRST: begin
        if (out_ready) begin
          inst_d  = pend_q;
          last_d  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      last_q  <= last_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus a randomized stream
// scored against an arithmetic model of the encoding rules.
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        out_err;

  typedef struct packed {
    logic [31:0] word;
    logic        last;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          xfer_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          rand_ready = 0;
  bit          hold_v = 0;
  logic [33:0] hold_val = '0;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_output(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from bit weights rather than field concatenation.
  function automatic void model(input logic [1:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
    int          v;
    bit          ok;
    logic [31:0] lo, hi, w;
    v  = imm;
    ok = (v >= -2048) && (v <= 2047);
    lo = imm & 32'hFFF;
    w  = 32'(op) + (32'(f3) << 12) + (32'(rs1) << 15);
    case (fmt)
      2'd0: exp_q.push_back('{w + (lo << 20) + (32'(rd) << 7), 1'b1, !ok});
      2'd1: exp_q.push_back('{w + ((lo >> 5) << 25) + (32'(rs2) << 20) + ((lo % 32) << 7),
                              1'b1, !ok});
      2'd2: exp_q.push_back('{w + (((lo >> 11) % 2) << 31) + (((lo >> 4) % 64) << 25)
                              + (32'(rs2) << 20) + ((lo % 16) << 8) + (((lo >> 10) % 2) << 7),
                              1'b1, !ok});
      default: begin
        if (ok) begin
          exp_q.push_back('{(lo << 20) + (32'(rd) << 7) + 32'h13, 1'b1, 1'b0});
        end else begin
          hi = (imm + 32'h800) >> 12;
          exp_q.push_back('{(hi << 12) + (32'(rd) << 7) + 32'h37, 1'b0, 1'b0});
          exp_q.push_back('{(lo << 20) + (32'(rd) << 15) + (32'(rd) << 7) + 32'h13,
                            1'b1, 1'b0});
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic l, input logic e);
    exp_q.push_back('{w, l, e});
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic apply_stimulus(input logic [1:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input bit use_model);
    bit done;
    done      = 0;
    in_fmt    = fmt;
    in_opcode = op;
    in_funct3 = f3;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_valid  = 1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (use_model) model(fmt, op, f3, rd, rs1, rs2, imm);
        acc_cyc = cyc;
        done    = 1;
      end
      tick();
    end
    in_valid = 0;
    if (!done) begin
      checks++;
      errors++;
      $error("[TB] FAIL accept_timeout observed=no_accept expected=accept");
    end
  endtask

  // Output scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check_output("hold_valid", {33'd0, out_valid}, 34'd1);
        check_output("hold_word", {out_inst, out_last, out_err}, hold_val);
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_word observed=%h expected=no_word", out_inst);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_output("word", {out_inst, out_last, out_err}, {e.word, e.last, e.err});
          xfer_cyc.push_back(cyc);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_inst, out_last, out_err};
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] corner [8];
    logic [31:0] imm;
    logic [1:0]  fmt;
    int          first_acc;

    corner[0] = -32'sd2049; corner[1] = -32'sd2048; corner[2] = 32'd2047;
    corner[3] = 32'd2048;   corner[4] = 32'd0;      corner[5] = 32'hFFFF_FFFF;
    corner[6] = 32'h7FFF_FFFF; corner[7] = 32'h8000_0000;

    rst = 1; in_valid = 0; out_ready = 1;
    in_fmt = 0; in_opcode = 0; in_funct3 = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    repeat (3) tick();
    @(negedge clk);
    check_output("reset_valid", {33'd0, out_valid}, 34'd0);
    check_output("reset_outputs", {out_inst, out_last, out_err}, 34'd0);
    tick();
    rst = 0;
    @(negedge clk);
    check_output("ready_after_reset", {33'd0, in_ready}, 34'd1);
    tick();

    // I, S, B back to back with the consumer always ready.
    xfer_cyc.delete();
    expect_word(32'hFFC12283, 1, 0);
    apply_stimulus(2'd0, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd4, 0);
    first_acc = acc_cyc;
    expect_word(32'h00612423, 1, 0);
    apply_stimulus(2'd1, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd6, 32'd8, 0);
    expect_word(32'hFE008EE3, 1, 0);
    apply_stimulus(2'd2, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd0, -32'sd2, 0);
    repeat (3) tick();
    check_output("b2b_count", 34'(xfer_cyc.size()), 34'd3);
    if (xfer_cyc.size() >= 3) begin
      check_output("latency", 34'(xfer_cyc[0] - first_acc), 34'd1);
      check_output("no_bubble", 34'(xfer_cyc[2] - xfer_cyc[0]), 34'd2);
    end

    // LI needing two words, with the consumer stalled on the LUI.
    out_ready = 0;
    expect_word(32'h12346537, 0, 0);
    expect_word(32'hFFF50513, 1, 0);
    apply_stimulus(2'd3, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF, 0);
    repeat (3) begin
      @(negedge clk);
      check_output("stall_in_ready", {33'd0, in_ready}, 34'd0);
      check_output("stall_lui", {out_inst, out_valid, out_last}, {32'h12346537, 1'b1, 1'b0});
      tick();
    end
    out_ready = 1;
    repeat (3) tick();
    check_output("li_drained", 34'(exp_q.size()), 34'd0);

    // Single-word LI and out-of-range flags.
    expect_word(32'h06400513, 1, 0);
    apply_stimulus(2'd3, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'd100, 0);
    expect_word(32'h80000513, 1, 0);
    apply_stimulus(2'd3, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, -32'sd2048, 0);
    expect_word(32'h80008083, 1, 1);
    apply_stimulus(2'd0, 7'b0000011, 3'b000, 5'd1, 5'd1, 5'd0, 32'd2048, 0);
    expect_word(32'h7E000FE3, 1, 1);
    apply_stimulus(2'd2, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, -32'sd2049, 0);
    repeat (3) tick();
    check_output("directed_drained", 34'(exp_q.size()), 34'd0);

    // Reset while the LUI is held: the pending ADDI must vanish.
    out_ready = 0;
    apply_stimulus(2'd3, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF, 0);
    rst = 1;
    exp_q.delete();
    tick();
    @(negedge clk);
    check_output("rst_mid_li_valid", {33'd0, out_valid}, 34'd0);
    check_output("rst_mid_li_ready", {33'd0, in_ready}, 34'd1);
    tick();
    rst = 0;
    out_ready = 1;
    repeat (5) tick();
    @(negedge clk);
    check_output("no_addi_after_rst", {33'd0, out_valid}, 34'd0);
    tick();

    // Randomized stream against the model with a randomly stalling consumer.
    rand_ready = 1;
    for (int n = 0; n < 250; n++) begin
      fmt = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = corner[$urandom_range(0, 7)];
        2: imm = $urandom;
        default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      endcase
      apply_stimulus(fmt, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), imm, 1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 0;
    tick();
    out_ready = 1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick();
    check_output("random_drained", 34'(exp_q.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
